// File: rtl/moving_avg4.sv
// Four-sample moving sum / truncated mean with valid/ready flow control.
// The first result appears on the 4th accepted sample; afterwards every accept yields one result.
module moving_avg4 #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW+1:0] out_sum,
  output logic [DW-1:0] out_avg,
  output logic [2:0]    fill_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // The producer holds its data until then; ready may depend combinationally on the
  // downstream ready, so a pending result consumed this edge frees the slot at once.

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_next;
  logic [2:0]    fill_next;
  logic          accept;
  logic          load;
  logic [DW-1:0] w0, w1, w2, w3;
  logic [DW+1:0] sum, sum_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !clr;

  // Oldest sample leaves as the newest enters; the true value is never negative.
  assign sum_next = sum + {2'b00, in_data} - {2'b00, w3};

  always_comb begin
    state_next = state;
    fill_next  = fill_cnt;
    load       = 1'b0;
    if (accept) begin
      if (state == FILL) begin
        fill_next = fill_cnt + 3'd1;
        if (fill_cnt == 3'd3) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end else begin
        load = 1'b1;
      end
    end
    if (clr) begin
      state_next = FILL;
      fill_next  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= 3'd0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0  <= '0;
      w1  <= '0;
      w2  <= '0;
      w3  <= '0;
      sum <= '0;
    end else if (clr) begin
      w0  <= '0;
      w1  <= '0;
      w2  <= '0;
      w3  <= '0;
      sum <= '0;
    end else if (accept) begin
      w0  <= in_data;
      w1  <= w0;
      w2  <= w1;
      w3  <= w2;
      sum <= sum_next;
    end
  end

  // A new result overrides a consume in the same edge, so streaming has no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_avg   <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_avg   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_sum   <= sum_next;
      out_avg   <= sum_next[DW+1:2];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_avg4.sv
// Bench for moving_avg4: directed scenarios plus random traffic, checked by a
// window-list reference model feeding an expected-result queue.
module tb_moving_avg4;

  localparam int DW = 12;
  localparam int MAXV = (1 << DW) - 1;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [DW+1:0] out_sum;
  logic [DW-1:0] out_avg;
  logic [2:0]    fill_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  int            win[$];
  bit            pend;
  logic [DW+1:0] exp_q[$];

  moving_avg4 #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .fill_cnt  (fill_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: present one cycle of inputs at the falling edge
  task automatic cycle(input bit v, input int d, input bit rdy, input bit c);
    @(negedge clk);
    in_valid  = v;
    in_data   = DW'(d);
    out_ready = rdy;
    clr       = c;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum",   32'(out_sum),   0);
    chk("rst_out_avg",   32'(out_avg),   0);
    chk("rst_fill_cnt",  32'(fill_cnt),  0);
    win.delete();
    pend = 1'b0;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // reference model: runs just before each rising edge with inputs stable
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      chk("reset_in_ready",  32'(in_ready),  1);
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_fill_cnt",  32'(fill_cnt),  0);
    end else begin
      bit exp_ready;
      bit acc;
      bit produced;
      exp_ready = !pend || out_ready;
      chk("in_ready",  32'(in_ready),  32'(exp_ready));
      chk("out_valid", 32'(out_valid), 32'(pend));
      chk("fill_cnt",  32'(fill_cnt),  32'(win.size()));
      acc = in_valid && exp_ready && !clr;
      produced = 1'b0;
      if (clr) begin
        if (pend && !out_ready && exp_q.size() > 0) void'(exp_q.pop_back());
        win.delete();
      end else if (acc) begin
        win.push_front(int'(in_data));
        if (win.size() > 4) void'(win.pop_back());
        if (win.size() == 4) begin
          int s;
          s = 0;
          foreach (win[i]) s += win[i];
          exp_q.push_back((DW+2)'(s));
          produced = 1'b1;
        end
      end
      pend = clr ? 1'b0 : (produced ? 1'b1 : (out_ready ? 1'b0 : pend));
    end
  end

  // monitor / scoreboard: compare each result as the downstream takes it
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 0);
      end else begin
        logic [DW+1:0] e;
        e = exp_q.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e));
        chk("out_avg", 32'(out_avg), 32'(e[DW+1:2]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = DW'(77); out_ready = 1'b0;
    pend = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #3 rst_n = 1'b1;

    // fill then stream
    cycle(1, 6, 1, 0); cycle(1, 15, 1, 0); cycle(1, 24, 1, 0);
    cycle(1, 3, 1, 0);
    #3 chk("no_result_before_4th", 32'(out_valid), 0);
    cycle(1, 40, 1, 0);
    #3 chk("first_sum", 32'(out_sum), 48);
    chk("first_avg", 32'(out_avg), 12);
    cycle(0, 0, 1, 0);
    #3 chk("second_sum", 32'(out_sum), 82);
    chk("second_avg", 32'(out_avg), 20);

    // backpressure with a pending result, then release with no bubble
    cycle(1, 10, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 20, 0, 0);
      #3 chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_frozen_sum", 32'(out_sum), 77);
    end
    cycle(1, 20, 1, 0);
    cycle(0, 0, 1, 0);
    #3 chk("bp_release_valid", 32'(out_valid), 1);
    chk("bp_release_sum", 32'(out_sum), 73);

    // clear in RUN drops the presented sample
    cycle(1, 100, 1, 1);
    cycle(1, 8, 1, 0);
    #3 chk("clr_fill_cnt", 32'(fill_cnt), 0);
    chk("clr_out_valid", 32'(out_valid), 0);
    cycle(1, 8, 1, 0); cycle(1, 8, 1, 0); cycle(1, 8, 1, 0);
    cycle(0, 0, 1, 0);
    #3 chk("clr_refill_sum", 32'(out_sum), 32);

    // full-scale samples
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, MAXV, 1, 0);
    cycle(0, 0, 1, 0);
    #3 chk("max_sum", 32'(out_sum), 16380);
    chk("max_avg", 32'(out_avg), 4095);

    // truncated mean, result left pending for the reset pulse
    cycle(0, 0, 1, 1);
    cycle(1, 1, 1, 0); cycle(1, 1, 1, 0); cycle(1, 1, 1, 0); cycle(1, 2, 0, 0);
    cycle(0, 0, 0, 0);
    #3 chk("trunc_sum", 32'(out_sum), 5);
    chk("trunc_avg", 32'(out_avg), 1);
    cycle(0, 0, 0, 0);
    mid_reset();
    for (int i = 0; i < 4; i++) cycle(1, 5, 1, 0);
    #3 chk("post_reset_no_early", 32'(out_valid), 0);
    cycle(0, 0, 1, 0);
    #3 chk("post_reset_sum", 32'(out_sum), 20);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int d;
      case ($urandom_range(0, 3))
        0:       d = MAXV;
        1:       d = 0;
        default: d = int'($urandom_range(0, MAXV));
      endcase
      cycle(bit'($urandom_range(0, 3) != 0), d, bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 40) == 0));
    end

    // drain
    repeat (3) cycle(0, 0, 1, 0);
    @(negedge clk);
    #3 chk("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moving_avg4.md
MOVING_AVG4 -- requirements
Module: moving_avg4

Interface
- REQ-001 The block SHALL have one parameter: DW, default 12, sample width matching the upstream 3-input pipeline sum output.
- REQ-002 The block SHALL have port clk, input, 1 bit, single clock, all state updates on rising edge.
- REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
- REQ-004 The block SHALL have port clr, input, 1 bit, synchronous window flush.
- REQ-005 The block SHALL have port in_valid, input, 1 bit, upstream sample present.
- REQ-006 The block SHALL have port in_data, input, DW bits, unsigned sample from the upstream pipeline.
- REQ-007 The block SHALL have port in_ready, output, 1 bit, block can accept a sample this cycle.
- REQ-008 The block SHALL have port out_ready, input, 1 bit, downstream accepts the result.
- REQ-009 The block SHALL have port out_valid, output, 1 bit, result registers hold an unconsumed result.
- REQ-010 The block SHALL have port out_sum, output, DW+2 bits, sum of the last 4 accepted samples.
- REQ-011 The block SHALL have port out_avg, output, DW bits, out_sum[DW+1:2], truncated mean.
- REQ-012 The block SHALL have port fill_cnt, output, 3 bits, accepted samples in the window, range 0..4.

Function
- REQ-013 The block SHALL keep a 4-deep sample history w0 (newest) to w3 (oldest) and a running sum register of DW+2 bits.
- REQ-014 A sample SHALL be accepted exactly when in_valid && in_ready && !clr at a rising edge.
- REQ-015 in_ready SHALL be combinational: !out_valid || out_ready. Acceptance is not blocked during FILL.
- REQ-016 On accept: sum <= sum + in_data - w3; w3<=w2, w2<=w1, w1<=w0, w0<=in_data. The sum SHALL never overflow, max 4*(2^DW-1).
- REQ-017 The state machine SHALL have two states, FILL and RUN:
  - FILL: fill_cnt < 4; each accept increments fill_cnt; the 4th accept moves to RUN.
  - RUN: fill_cnt stays 4.
- REQ-018 Output generation:
  - An accept that leaves fill_cnt == 4 (4th accept in FILL, or any accept in RUN) SHALL load out_sum/out_avg with the new sum and set out_valid at the same edge.
  - Latency is 1 cycle, from the accepting edge to the registered result.
  - Accepts 1-3 SHALL produce no output.
- REQ-019 out_sum/out_avg SHALL remain stable while out_valid && !out_ready.
- REQ-020 When out_valid && out_ready and no new result is loaded at that edge, out_valid SHALL fall to 0.
- REQ-021 Simultaneous consume and new result at the same edge: the new result SHALL load and out_valid SHALL stay 1, with no bubble.
- REQ-022 clr=1 SHALL have priority over accept:
  - Zero w0-w3, sum, out_sum, out_avg and fill_cnt.
  - Clear out_valid and return to FILL.
  - in_data presented in the same cycle is dropped.
- REQ-023 in_data SHALL be ignored when in_valid=0; in_valid asserted while in_ready=0 SHALL not change state. Upstream holds its data.

Reset
- REQ-024 rst_n=0 SHALL immediately, with no clock needed, set:
  - w0-w3, sum, out_sum, out_avg = 0
  - fill_cnt = 0, out_valid = 0, state = FILL
- REQ-025 While rst_n=0, in_ready SHALL read 1 per REQ-015, but no accept SHALL occur.
- REQ-026 Reset asserted mid-stream SHALL discard the window and any pending result. The first result after release requires 4 new accepts.

Verification
- REQ-027 Fill then stream: out_ready=1, samples 6,15,24,3 on consecutive cycles -> no out_valid for the first 3, then out_valid=1 with out_sum=48, out_avg=12. A 5th sample 40 -> out_sum=82, out_avg=20.
- REQ-028 Backpressure: window full, out_ready=0, a result pending -> in_ready=0, outputs frozen for 5 cycles. Raising out_ready then loads the next sample and delivers it with no bubble.
- REQ-029 Max value: DW=12, four samples of 4095 -> out_sum=16380, out_avg=4095, no wrap.
- REQ-030 Truncation: samples 1,1,1,2 -> out_sum=5, out_avg=1.
- REQ-031 clr with in_valid=1, in_data=100 in RUN -> fill_cnt=0, out_valid=0, sample dropped. The next 4 samples of 8 -> out_sum=32.
- REQ-032 Reset mid-operation: rst_n=0 pulse between clock edges with fill_cnt=4 and out_valid=1 -> all outputs 0 immediately. The first result after release appears only after the 4th new accept.
